// File: rtl/axis_fifo_pkg.sv
// Shared types and sizing helpers for the axis_sync_fifo RAM-backed stream FIFO.
package axis_fifo_pkg;

    localparam int unsigned BEAT_DLEN = 8;

    typedef struct packed {
        logic [BEAT_DLEN-1:0] data;
        logic                 last;
    } axis_beat_t;

    // Encoding doubles as the skid occupancy (0, 1 or 2 entries).
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    function automatic int unsigned fifo_depth(input int unsigned alen);
        return 32'd1 << alen;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/SdpRam1.sv
// Simple dual-port RAM: one write port, one read port; OREG=1 registers the read data (1-cycle latency).
module SdpRam1 #(
    parameter int unsigned ALEN = 2,
    parameter int unsigned DLEN = 8,
    parameter int unsigned OREG = 1
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [ALEN-1:0] i_waddr,
    input  logic [DLEN-1:0] i_wdata,
    input  logic            i_re,
    input  logic [ALEN-1:0] i_raddr,
    output logic [DLEN-1:0] o_rdata
);

    logic [DLEN-1:0] mem_q [2**ALEN];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    generate
        if (OREG != 0) begin : g_oreg
            logic [DLEN-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (i_re) begin
                    rdata_q <= mem_q[i_raddr];
                end
            end
            assign o_rdata = rdata_q;
        end else begin : g_comb
            logic unused_re;
            assign unused_re = i_re;
            assign o_rdata   = mem_q[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/axis_fifo_out_skid.sv
// Two-entry output buffer in FIFO order driving the master stream; head holds while stalled.
module axis_fifo_out_skid
    import axis_fifo_pkg::*;
#(
    parameter type beat_t = axis_beat_t
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_wr,
    input  beat_t       i_wr_beat,
    input  logic        i_m_tready,
    output logic        o_m_tvalid,
    output beat_t       o_m_beat,
    output skid_state_e o_state
);

    skid_state_e state_q, state_d;
    beat_t       head_q, head_d, tail_q, tail_d;
    logic        pop;

    assign o_m_tvalid = (state_q != SKID_EMPTY);
    assign pop        = o_m_tvalid & i_m_tready;
    assign o_m_beat   = head_q;
    assign o_state    = state_q;

    // The prefetch engine never writes while two entries are held and none leaves.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            SKID_EMPTY: begin
                if (i_wr) begin
                    head_d  = i_wr_beat;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (pop && i_wr) begin
                    head_d = i_wr_beat;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end else if (i_wr) begin
                    tail_d  = i_wr_beat;
                    state_d = SKID_TWO;
                end
            end
            SKID_TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    if (i_wr) begin
                        tail_d = i_wr_beat;
                    end else begin
                        state_d = SKID_ONE;
                    end
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= SKID_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO: RAM pointers, occupancy and read prefetch into a 2-entry output skid.
// Define AXIS_FIFO_TLAST_EN to store tlast with tdata in the RAM; otherwise o_m_tlast is tied 0.
module axis_sync_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DLEN  = 8,
    parameter int unsigned ALEN  = 2,
    parameter int unsigned AFULL = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_s_tvalid,
    output logic            o_s_tready,
    input  logic [DLEN-1:0] i_s_tdata,
    input  logic            i_s_tlast,
    output logic            o_m_tvalid,
    input  logic            i_m_tready,
    output logic [DLEN-1:0] o_m_tdata,
    output logic            o_m_tlast,
    output logic [ALEN+1:0] o_count,
    output logic            o_almost_full
);

    localparam int unsigned DEPTH = fifo_depth(ALEN);
    localparam int unsigned RCW   = cnt_width(DEPTH);
    localparam int unsigned CW    = ALEN + 2;
    localparam logic [RCW-1:0] RAM_FULL    = RCW'(DEPTH);
    localparam logic [RCW-1:0] RAM_FULL_M1 = RCW'(DEPTH - 1);
    localparam logic [CW-1:0]  CAP         = CW'(DEPTH + 2);
    localparam logic [CW-1:0]  AFULL_W     = CW'(AFULL);
`ifdef AXIS_FIFO_TLAST_EN
    localparam int unsigned RW = DLEN + 1;
`else
    localparam int unsigned RW = DLEN;
`endif

    typedef struct packed {
        logic [DLEN-1:0] data;
        logic            last;
    } fifo_beat_t;

    logic [ALEN-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [RCW-1:0]  ram_cnt_q, ram_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic            inflight_q, inflight_d, s_tready_q, s_tready_d;
    logic            push, pop, rd_issue, m_tvalid;
    logic [1:0]      skid_occ;
    logic [2:0]      skid_after;
    logic [RW-1:0]   ram_wdata, ram_rdata;
    fifo_beat_t      ram_beat, m_beat;
    skid_state_e     skid_state;

    // Both ports transfer on a rising edge where valid & ready are high; valid never waits on ready.
    assign push = i_s_tvalid & s_tready_q;
    assign pop  = m_tvalid & i_m_tready;

    // Read only if the beat will still have a skid slot when it lands next cycle.
    assign skid_occ   = skid_state;
    assign skid_after = 3'(skid_occ) + 3'(inflight_q) - 3'(pop);
    assign rd_issue   = (ram_cnt_q != '0) && (skid_after < 3'd2);

    always_comb begin
        wptr_d     = wptr_q + ALEN'(push);
        rptr_d     = rptr_q + ALEN'(rd_issue);
        inflight_d = rd_issue;
        ram_cnt_d  = ram_cnt_q;
        count_d    = count_q;
        if (push && !rd_issue) ram_cnt_d = ram_cnt_q + RCW'(1);
        if (!push && rd_issue) ram_cnt_d = ram_cnt_q - RCW'(1);
        if (push && !pop)      count_d   = count_q + CW'(1);
        if (!push && pop)      count_d   = count_q - CW'(1);
        s_tready_d = !((ram_cnt_q == RAM_FULL) || ((ram_cnt_q == RAM_FULL_M1) && push));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            s_tready_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            s_tready_q <= s_tready_d;
        end
    end

`ifdef AXIS_FIFO_TLAST_EN
    assign ram_wdata = {i_s_tlast, i_s_tdata};
    assign ram_beat  = '{data: ram_rdata[DLEN-1:0], last: ram_rdata[DLEN]};
`else
    logic unused_tlast;
    assign unused_tlast = i_s_tlast;
    assign ram_wdata    = i_s_tdata;
    assign ram_beat     = '{data: ram_rdata, last: 1'b0};
`endif

    SdpRam1 #(.ALEN(ALEN), .DLEN(RW), .OREG(1)) u_ram (
        .clk     (clk),
        .i_we    (push),
        .i_waddr (wptr_q),
        .i_wdata (ram_wdata),
        .i_re    (rd_issue),
        .i_raddr (rptr_q),
        .o_rdata (ram_rdata)
    );

    axis_fifo_out_skid #(.beat_t(fifo_beat_t)) u_skid (
        .clk        (clk),
        .rstn       (rstn),
        .i_wr       (inflight_q),
        .i_wr_beat  (ram_beat),
        .i_m_tready (i_m_tready),
        .o_m_tvalid (m_tvalid),
        .o_m_beat   (m_beat),
        .o_state    (skid_state)
    );

    assign o_s_tready    = s_tready_q;
    assign o_m_tvalid    = m_tvalid;
    assign o_m_tdata     = m_beat.data;
    assign o_m_tlast     = m_beat.last;
    assign o_count       = count_q;
    assign o_almost_full = (CAP - count_q) <= AFULL_W;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && (count_q == CAP)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
        !(pop && (count_q == '0)));

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench for axis_sync_fifo (ALEN=2: RAM depth 4, total capacity 6).
module tb_axis_sync_fifo;

    localparam int DLEN = 8;
    localparam int ALEN = 2;
`ifdef AXIS_FIFO_TLAST_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn;
    logic            s_tvalid, s_tready, s_tlast;
    logic [DLEN-1:0] s_tdata;
    logic            m_tvalid, m_tready, m_tlast;
    logic [DLEN-1:0] m_tdata;
    logic [ALEN+1:0] count;
    logic            afull;

    logic [DLEN:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [3:0] fill_cnt   [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6};
    logic       fill_afull [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       fill_rdy   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       last_vec   [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    axis_sync_fifo #(.DLEN(DLEN), .ALEN(ALEN), .AFULL(1)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_s_tvalid    (s_tvalid),
        .o_s_tready    (s_tready),
        .i_s_tdata     (s_tdata),
        .i_s_tlast     (s_tlast),
        .o_m_tvalid    (m_tvalid),
        .i_m_tready    (m_tready),
        .o_m_tdata     (m_tdata),
        .o_m_tlast     (m_tlast),
        .o_count       (count),
        .o_almost_full (afull)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; s_tvalid = 1'b1; s_tdata = 8'h55; s_tlast = 1'b1; m_tready = 1'b1;
        repeat (3) step();
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got %b exp 0", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %b exp 0", m_tvalid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL rst_m_tdata got %h exp 00", m_tdata); end
        checks++; if (afull !== 1'b0) begin errors++; $display("FAIL rst_afull got %b exp 0", afull); end
        rstn = 1'b1;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rel_pre_ready got %b exp 0", s_tready); end
        step();
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", s_tready); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rel_count got %0d exp 0", count); end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic test_single();
        m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b0;
        step();
        s_tvalid = 1'b0;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_cnt_n got %0d exp 1", count); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_vld_n got %b exp 0", m_tvalid); end
        step();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_vld_n1 got %b exp 0", m_tvalid); end
        step();
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL single_vld_n2 got %b exp 1", m_tvalid); end
        checks++; if (m_tdata !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", m_tdata); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_cnt_n2 got %0d exp 1", count); end
        m_tready = 1'b1;
        step();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_pop_vld got %b exp 0", m_tvalid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_pop_cnt got %0d exp 0", count); end
        m_tready = 1'b0;
    endtask

    task automatic test_fill();
        m_tready = 1'b0; s_tlast = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'(i + 1);
            checks++; if (s_tready !== fill_rdy[(i == 0) ? 0 : i - 1] && i > 0) begin
                errors++; $display("FAIL fill_pre_rdy[%0d] got %b exp %b", i, s_tready, fill_rdy[i - 1]);
            end
            step();
            checks++; if (count !== fill_cnt[i]) begin errors++; $display("FAIL fill_cnt[%0d] got %0d exp %0d", i, count, fill_cnt[i]); end
            checks++; if (afull !== fill_afull[i]) begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, afull, fill_afull[i]); end
            checks++; if (s_tready !== fill_rdy[i]) begin errors++; $display("FAIL fill_rdy[%0d] got %b exp %b", i, s_tready, fill_rdy[i]); end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            int guard = 0;
            while (m_tvalid !== 1'b1 && guard < 8) begin step(); guard++; end
            checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'(k)) begin
                errors++; $display("FAIL drain[%0d] got vld %b data %h exp vld 1 data %h", k, m_tvalid, m_tdata, 8'(k));
            end
            step();
        end
        step();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL drain_empty_vld got %b exp 0", m_tvalid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_empty_cnt got %0d exp 0", count); end
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL drain_rdy got %b exp 1", s_tready); end
        m_tready = 1'b0;
    endtask

    task automatic test_streaming();
        exp_q.delete();
        for (int c = 0; c < 40; c++) begin
            s_tvalid = (c < 32); s_tdata = 8'(8'h20 + c); s_tlast = 1'b0; m_tready = 1'b1;
            if (c >= 3 && c < 32) begin
                checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL stream_bubble[%0d] got %b exp 1", c, m_tvalid); end
                checks++; if (count !== 4'd3) begin errors++; $display("FAIL stream_cnt[%0d] got %0d exp 3", c, count); end
            end
            if (s_tvalid && s_tready) exp_q.push_back({1'b0, s_tdata});
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra got %h exp none", m_tdata);
                end else begin
                    if ({m_tlast, m_tdata} !== exp_q[0]) begin
                        errors++; $display("FAIL stream_data got %h exp %h", {m_tlast, m_tdata}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            step();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_left got %0d exp 0", exp_q.size()); end
        s_tvalid = 1'b0; m_tready = 1'b0;
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int rcvd = 0;
        bit stalled = 1'b0;
        logic [DLEN:0] prev = '0;
        exp_q.delete();
        for (int c = 0; c < 3000 && rcvd < 200; c++) begin
            s_tvalid = (sent < 200); s_tdata = 8'(sent * 7 + 3); s_tlast = ((sent % 3) == 2);
            m_tready = 1'($urandom_range(0, 1));
            if (stalled) begin
                checks++; if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== prev) begin
                    errors++; $display("FAIL bp_hold got vld %b beat %h exp vld 1 beat %h", m_tvalid, {m_tlast, m_tdata}, prev);
                end
            end
            if (s_tvalid && s_tready) begin exp_q.push_back({TLAST_EN & s_tlast, s_tdata}); sent++; end
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra got %h exp none", m_tdata);
                end else begin
                    if ({m_tlast, m_tdata} !== exp_q[0]) begin
                        errors++; $display("FAIL bp_data[%0d] got %h exp %h", rcvd, {m_tlast, m_tdata}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                rcvd++;
            end
            stalled = m_tvalid && !m_tready;
            prev = {m_tlast, m_tdata};
            step();
            checks++; if (count !== 4'(exp_q.size())) begin errors++; $display("FAIL bp_cnt got %0d exp %0d", count, exp_q.size()); end
            checks++; if (afull !== ((6 - exp_q.size()) <= 1)) begin errors++; $display("FAIL bp_afull got %b at size %0d", afull, exp_q.size()); end
        end
        checks++; if (rcvd != 200) begin errors++; $display("FAIL bp_timeout got %0d words exp 200", rcvd); end
        s_tvalid = 1'b0; m_tready = 1'b0;
    endtask

    task automatic test_tlast();
        int sent = 0;
        int rcvd = 0;
        for (int c = 0; c < 40 && rcvd < 9; c++) begin
            s_tvalid = (sent < 9); s_tdata = 8'(8'h90 + sent);
            s_tlast = (sent < 9) ? last_vec[sent] : 1'b0;
            m_tready = 1'b1;
            if (s_tvalid && s_tready) sent++;
            if (m_tvalid) begin
                checks++; if (m_tdata !== 8'(8'h90 + rcvd) || m_tlast !== (last_vec[rcvd] & TLAST_EN)) begin
                    errors++; $display("FAIL tlast_word[%0d] got %b/%h exp %b/%h", rcvd + 1, m_tlast, m_tdata,
                                       last_vec[rcvd] & TLAST_EN, 8'(8'h90 + rcvd));
                end
                rcvd++;
            end
            step();
        end
        checks++; if (rcvd != 9) begin errors++; $display("FAIL tlast_timeout got %0d words exp 9", rcvd); end
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    endtask

    task automatic test_mid_reset();
        m_tready = 1'b0; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin s_tdata = 8'(8'hC0 + i); step(); end
        s_tvalid = 1'b0;
        step(); step();
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mrst_pre_vld got %b exp 1", m_tvalid); end
        rstn = 1'b0;
        step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL mrst_cnt got %0d exp 0", count); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mrst_vld got %b exp 0", m_tvalid); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL mrst_rdy got %b exp 0", s_tready); end
        rstn = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mrst_after_vld[%0d] got %b exp 0", i, m_tvalid); end
        end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL mrst_after_cnt got %0d exp 0", count); end
        m_tready = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_streaming();
        test_backpressure();
        test_tlast();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t exp finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
